bus_arbiter: RTL

- Round-robin arbiter and sequencer for the shared 10-register tri-state datapath bus.
- Up to N_REQ requesters (instruction controller, I/O loader, debug port, ...) each present a source and destination register index. The block grants one requester per transfer and drives the one-hot tri-state source select and one-hot register load enable.
- A requester may lock the bus for a bounded multi-cycle burst.

---
 rtl/bus_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter/sequencer for the shared register bus, with bounded lock bursts.
// Optional macro BUS_ARB_PRIO_EN gives requester 0 fixed highest priority at arbitration points.
module bus_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned N_REG    = 10,
  parameter int unsigned IDX_W    = 5,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       lock,
  input  logic [N_REQ*IDX_W-1:0] src_idx,
  input  logic [N_REQ*IDX_W-1:0] dst_idx,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REG-1:0]       tri_controller_OH,
  output logic [N_REG-1:0]       r_en_OH,
  output logic                   busy,
  output logic                   idx_err
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_HOLD} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REG-1:0]   tri_q, tri_d;
  logic [N_REG-1:0]   ren_q, ren_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic               sel_valid;
  logic               found;
  logic               prio_win;
  logic               hold_stay;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   cand;
  logic [IDX_W-1:0]   src_sel;
  logic [IDX_W-1:0]   dst_sel;
  logic               src_bad;
  logic               dst_bad;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      tri_q   <= '0;
      ren_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      tri_q   <= tri_d;
      ren_q   <= ren_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Next state: continue a lock burst, otherwise arbitrate in the same edge
  always_comb begin
    state_d   = S_IDLE;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = '0;
    sel_valid = 1'b0;
    found     = 1'b0;
    win       = '0;
    cand      = '0;

    for (int i = 0; i < int'(N_REQ); i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % int'(N_REQ));
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end

`ifdef BUS_ARB_PRIO_EN
    prio_win = req[0];
`else
    prio_win = 1'b0;
`endif

    hold_stay = (state_q == S_HOLD) && req[owner_q] && lock[owner_q]
                && (cnt_q < CNT_W'(MAX_HOLD));

    if (hold_stay) begin
      state_d   = S_HOLD;
      cnt_d     = cnt_q + CNT_W'(1);
      sel_valid = 1'b1;
    end else if (prio_win) begin
      // Fixed-priority win leaves the round-robin pointer untouched
      owner_d   = '0;
      state_d   = lock[0] ? S_HOLD : S_GRANT;
      cnt_d     = lock[0] ? CNT_W'(1) : '0;
      sel_valid = 1'b1;
    end else if (found) begin
      owner_d   = win;
      ptr_d     = PTR_W'((int'(win) + 1) % int'(N_REQ));
      state_d   = lock[win] ? S_HOLD : S_GRANT;
      cnt_d     = lock[win] ? CNT_W'(1) : '0;
      sel_valid = 1'b1;
    end
  end

  // Output decode for the selected owner; out-of-range indices give no enable
  always_comb begin
    gnt_d   = '0;
    tri_d   = '0;
    ren_d   = '0;
    busy_d  = sel_valid;
    src_sel = src_idx[int'(owner_d)*int'(IDX_W) +: IDX_W];
    dst_sel = dst_idx[int'(owner_d)*int'(IDX_W) +: IDX_W];
    src_bad = 32'(src_sel) >= N_REG;
    dst_bad = 32'(dst_sel) >= N_REG;
    err_d   = sel_valid && (src_bad || dst_bad);
    if (sel_valid) begin
      gnt_d = N_REQ'(1) << owner_d;
      if (!src_bad) tri_d = N_REG'(1) << src_sel;
      if (!dst_bad) ren_d = N_REG'(1) << dst_sel;
    end
  end

  assign gnt               = gnt_q;
  assign tri_controller_OH = tri_q;
  assign r_en_OH           = ren_q;
  assign busy              = busy_q;
  assign idx_err           = err_q;

endmodule
